// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Misaligned word access, or word index beyond the array.
  function automatic logic addr_error(input logic [63:0] addr, input int unsigned depth);
    logic [63:0] word_idx;
    word_idx = addr / 64'(WORD_BYTES);
    return (addr[1:0] != 2'b00) || (word_idx >= 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// Loadable down-counter that times the gap between request accept and response.
module dmem_latency_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the MEM-stage load/store interface: one outstanding word
// request, fixed response latency, busy used as a pipeline stall source.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 3,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              busy
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_write;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_req_err;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_done;
  logic             w_enter_resp;
  logic             w_tx_write;
  logic [IDX_W-1:0] w_tx_idx;
  logic [31:0]      w_tx_wdata;
  logic             w_tx_err;
  logic [31:0]      w_rdata;

  assign req_ready = (r_state != WAIT);
  assign busy      = (r_state == WAIT);
  assign w_accept  = req_valid && req_ready;
  assign w_req_err = addr_error(64'(req_addr), DEPTH_WORDS);

  dmem_latency_counter #(
    .WIDTH (CNT_W)
  ) u_latency_counter (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_INIT),
    .i_dec      (w_cnt_dec),
    .o_done     (w_cnt_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_load  = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (w_cnt_done) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // With single-cycle latency the transaction completes on its own accept
  // edge, so it is taken straight from the request lines, not the latches.
  assign w_enter_resp = (w_state_nxt == RESP);
  assign w_tx_write   = (LATENCY == 1) ? req_write              : r_write;
  assign w_tx_idx     = (LATENCY == 1) ? req_addr[IDX_W+1:2]    : r_idx;
  assign w_tx_wdata   = (LATENCY == 1) ? req_wdata              : r_wdata;
  assign w_tx_err     = (LATENCY == 1) ? w_req_err              : r_err;
  assign w_rdata      = r_mem[w_tx_idx];

  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && w_tx_write && !w_tx_err) begin
      r_mem[w_tx_idx] <= w_tx_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_idx   <= req_addr[IDX_W+1:2];
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
      end
      resp_valid <= w_enter_resp;
      resp_rdata <= (w_enter_resp && !w_tx_write && !w_tx_err) ? w_rdata : '0;
      resp_error <= w_enter_resp && w_tx_err;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 3, 1 and 4, with a per-instance
// scoreboard of expected responses and their due cycles.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } exp_t;

  localparam int unsigned LATS [3] = '{3, 1, 4};

  logic        clk = 1'b0;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_error [3];
  logic        busy       [3];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0 [$];
  exp_t        q1 [$];
  exp_t        q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .ADDR_W(32)) u_dut_l3 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]),
    .busy(busy[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .ADDR_W(32)) u_dut_l1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]),
    .busy(busy[1]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .ADDR_W(32)) u_dut_l4 (
    .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]),
    .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int d, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{32'h0, 1'b0, 0};
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic monitor(input int d);
    exp_t e;
    bit   ok;
    if (resp_valid[d] === 1'b1) begin
      pop(d, e, ok);
      if (!ok) begin
        checks++;
        errors++;
        $error("FAIL unexpected_resp[%0d]: observed resp_valid at cycle %0d expected none", d, cyc);
      end else begin
        check($sformatf("resp_rdata[%0d]", d), resp_rdata[d], e.rdata);
        check($sformatf("resp_error[%0d]", d), 32'(resp_error[d]), 32'(e.err));
        check($sformatf("resp_cycle[%0d]", d), cyc, e.due);
      end
    end else begin
      check($sformatf("idle_rdata[%0d]", d), resp_rdata[d], 32'h0);
      check($sformatf("idle_error[%0d]", d), 32'(resp_error[d]), 32'h0);
    end
    if (d == 1) begin
      check("l1_busy_never", 32'(busy[1]), 32'h0);
      check("l1_ready_always", 32'(req_ready[1]), 32'h1);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) monitor(d);
  end

  // Present a request at a falling edge and wait (bounded) for acceptance;
  // returns just after the accepting edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input bit hold, input bit expect_resp, input logic [31:0] erd,
                       input logic eerr, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    while (req_ready[d] !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (req_ready[d] !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout[%0d]: observed req_ready=%b expected 1", d, req_ready[d]);
      req_valid[d] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (expect_resp) begin
        e = '{erd, eerr, cyc + LATS[d] - 1};
        push(d, e);
      end
      if (!hold) req_valid[d] = 1'b0;
    end
  endtask

  initial begin
    int w;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ready[%0d]", d), 32'(req_ready[d]), 32'h1);
      check($sformatf("rst_busy[%0d]", d), 32'(busy[d]), 32'h0);
      check($sformatf("rst_valid[%0d]", d), 32'(resp_valid[d]), 32'h0);
      check($sformatf("rst_rdata[%0d]", d), resp_rdata[d], 32'h0);
      check($sformatf("rst_error[%0d]", d), 32'(resp_error[d]), 32'h0);
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // LATENCY=3: store/load, misaligned store, out-of-range load
    issue(0, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b0, w);
    check("l3_busy_after_accept", 32'(busy[0]), 32'h1);
    issue(0, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, w);
    issue(0, 1'b1, 32'h13,   32'h1234,     1'b0, 1'b1, 32'h0,        1'b1, w);
    issue(0, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, w);
    issue(0, 1'b0, 32'h1000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, w);

    // Reset mid-WAIT aborts the store
    issue(0, 1'b1, 32'h20,   32'h11112222, 1'b0, 1'b1, 32'h0,        1'b0, w);
    issue(0, 1'b1, 32'h20,   32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        1'b0, w);
    check("abort_busy_before", 32'(busy[0]), 32'h1);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    check("abort_valid", 32'(resp_valid[0]), 32'h0);
    check("abort_busy", 32'(busy[0]), 32'h0);
    check("abort_ready", 32'(req_ready[0]), 32'h1);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    repeat (5) @(negedge clk);
    issue(0, 1'b0, 32'h20,   32'h0,        1'b0, 1'b1, 32'h11112222, 1'b0, w);

    // LATENCY=1: back-to-back loads with req_valid held
    issue(1, 1'b1, 32'h0, 32'hAAAA0000, 1'b0, 1'b1, 32'h0, 1'b0, w);
    issue(1, 1'b1, 32'h4, 32'hBBBB0004, 1'b0, 1'b1, 32'h0, 1'b0, w);
    issue(1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hAAAA0000, 1'b0, w);
    check("l1_first_wait", 32'(w), 32'h0);
    issue(1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'hBBBB0004, 1'b0, w);
    check("l1_second_wait", 32'(w), 32'h0);

    // LATENCY=4: request during WAIT is held off until RESP
    issue(2, 1'b1, 32'h8, 32'hA5A50001, 1'b0, 1'b1, 32'h0, 1'b0, w);
    check("l4_busy_wait", 32'(busy[2]), 32'h1);
    check("l4_ready_wait", 32'(req_ready[2]), 32'h0);
    issue(2, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'hA5A50001, 1'b0, w);
    check("l4_accept_in_resp", 32'(w), 32'h3);

    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    check("drain_q0", 32'(q0.size()), 32'h0);
    check("drain_q1", 32'(q1.size()), 32'h0);
    check("drain_q2", 32'(q2.size()), 32'h0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory side of the pipeline's MEM-stage load/store request interface.
- Accepts one word load or store per request and holds it for a configurable latency.
- Returns read data or completion with an error flag; its busy output feeds the hazard unit as a stall source.
- Single outstanding request; no response backpressure, because the core is stalled while busy.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the storage array; power of two, at least 4.
- LATENCY, 3, cycles from request acceptance to resp_valid; at least 1.
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  MEM stage presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store word, 0 = load word.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  one-cycle pulse marking completion.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_error  output  1  misaligned or out-of-range access; qualified by resp_valid.
- busy  output  1  request in flight, no response yet; stall source.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_error = 0, busy = 0, req_ready = 1.
  - An in-flight request is aborted: no array write, no response.
  - Array contents are not cleared.
- States:
  - IDLE: waiting for a request.
  - WAIT: counting latency.
  - RESP: resp_valid high for exactly one cycle.
- Accept: on any clock edge where req_valid && req_ready.
  - Latch write flag, address, wdata.
  - Compute error = (req_addr[1:0] != 0) || (req_addr[ADDR_W-1:2] >= DEPTH_WORDS).
- Transitions after accept:
  - LATENCY == 1: go straight to RESP.
  - LATENCY > 1: go to WAIT with counter = LATENCY-2; WAIT decrements each cycle; at counter == 0 go to RESP.
- Timing: request accepted at edge t gives resp_valid high in the cycle after edge t+LATENCY-1. That is exactly LATENCY cycles after the accepting cycle.
- Array update: on the edge entering RESP.
  - Store without error: writes wdata to word addr[log2(DEPTH_WORDS)+1:2].
  - Load without error: resp_rdata is registered from the array on the same edge.
  - Error: no write, resp_rdata = 0, resp_error = 1.
- Outputs by state:
  - req_ready = 1 in IDLE and RESP, 0 in WAIT. A request accepted during RESP starts a new transaction with no idle bubble.
  - busy = 1 in WAIT, and in the accept cycle's successor until RESP. Equivalently: busy = (state == WAIT).
  - With LATENCY == 1, busy is never asserted.
- Response outputs are held at 0 whenever resp_valid == 0.
- A load following a store to the same address returns the stored value; ordering is guaranteed by the single outstanding request.
- req_valid with req_ready == 0 is ignored. The requester must hold the request.
- Counter width is $clog2(LATENCY); minimum 1 bit.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - Constant WORD_BYTES = 4.
  - Function addr_error(addr, depth).
- One sub-module: dmem_latency_counter.
  - Load, decrement, done flag.
  - Asynchronous reset to 0.
  - Instantiated once.

Test Plan:
- Store then load, LATENCY=3: store 0xDEADBEEF to 0x10, then load 0x10 → resp_valid 3 cycles after each accept; load resp_rdata = 0xDEADBEEF, resp_error = 0; store resp_rdata = 0.
- LATENCY=1, back-to-back loads at 0x0 and 0x4 with req_valid held high → req_ready stays 1, resp_valid high on two consecutive cycles, busy never asserted.
- Misaligned store to 0x13 with data 0x1234 → resp_error = 1, resp_rdata = 0; a subsequent load of 0x10 returns its prior value, unchanged.
- Out-of-range load at 4*DEPTH_WORDS (0x1000 at default) → resp_error = 1, resp_rdata = 0, latency unchanged.
- Reset asserted mid-WAIT of a store of 0xCAFEF00D to 0x20 → outputs go to their reset values immediately; no resp_valid; a later load of 0x20 returns the pre-store value.
- Request presented during WAIT with LATENCY=4 → req_ready = 0 and busy = 1; the request is accepted in the RESP cycle, and its response follows 4 cycles later.
